ifetch_queue: RTL and testbench
===============================

IFETCH_QUEUE -- requirements
Module: ifetch_queue

Interface
REQ-001 Parameter DEPTH, default 4, sets the prefetch queue depth in entries (power of two, at least 2).
REQ-002 Parameter RESET_PC, default 32'h0000_0000, is the first fetch address after reset.
REQ-003 clock  in  1  is the single clock; all state updates on its rising edge.
REQ-004 reset_n  in  1  is a synchronous, active-low reset, sampled on the rising edge of clock.
REQ-005 imem_req  out  1  requests an instruction memory read.
REQ-006 imem_addr  out  32  is the byte address of the read; bits [1:0] are always 00.
REQ-007 imem_ack  in  1  means imem_rdata is valid and the request completes this cycle.
REQ-008 imem_rdata  in  32  is the instruction word.
REQ-009 redirect  in  1  is the branch/jump taken pulse from ID/EX.
REQ-010 redirect_pc  in  32  is the new fetch address; bits [1:0] are ignored and treated as 00.
REQ-011 stall  in  1  is the decode interlock: it holds the IF/ID outputs.
REQ-012 ifid_ir  out  32  is the instruction presented to decode; 32'h0 (noop) when not valid.
REQ-013 ifid_pc4  out  32  is the address of ifid_ir plus 4.
REQ-014 ifid_valid  out  1  means ifid_ir holds a fetched instruction.
REQ-015 fifo_count  out  log2(DEPTH)+1  is the current number of queue entries.

Function
REQ-016 The fetch FSM SHALL have three states: IDLE (no request), REQ (imem_req=1, imem_addr=fpc) and DROP (imem_req=1 with the pre-redirect address; response will be discarded).
REQ-017 imem_req and imem_addr SHALL remain stable from assertion until the cycle in which imem_ack=1; a same-cycle ack SHALL be legal, giving 1 fetch per cycle.
REQ-018 A new request SHALL be issued only while fifo_count after this cycle's pop is less than DEPTH, so the queue never overflows.
REQ-019 IDLE->REQ when space exists; REQ->REQ on ack when space remains after the push; REQ->IDLE on ack when the queue becomes full.
REQ-020 In REQ, an ack SHALL push {imem_rdata, fpc+4} and advance fpc by 4, wrapping modulo 2^32.
REQ-021 The output register SHALL follow this priority. redirect: ifid_ir=0, ifid_valid=0, ifid_pc4 held. Else !stall and queue non-empty: pop the head into the outputs with ifid_valid=1. Else !stall and queue empty: ifid_ir=0, ifid_valid=0. Else stall: hold all outputs.
REQ-022 Minimum latency SHALL be 2 edges: data acked at edge N appears on ifid_ir at edge N+1, with no bypass around the queue.
REQ-023 Simultaneous push and pop SHALL leave fifo_count unchanged; the head and tail pointers SHALL wrap modulo DEPTH.
REQ-024 On redirect, the same edge SHALL empty the queue and load fpc=redirect_pc.
REQ-025 Redirect from IDLE or REQ with no ack that cycle SHALL go to REQ (from IDLE) or to DROP (from REQ).
REQ-026 Redirect in REQ with an ack the same cycle SHALL discard the data and go to REQ at redirect_pc.
REQ-027 In DROP, the ack SHALL be discarded with no push and no fpc change, and the FSM SHALL go to REQ.
REQ-028 A further redirect while in DROP SHALL update fpc only; the FSM stays in DROP.
REQ-029 redirect SHALL override stall; stall SHALL NOT block fetching into the queue.

Reset
REQ-030 With reset_n=0 at an edge: state=IDLE, fpc=RESET_PC, queue empty, fifo_count=0, ifid_ir=0, ifid_pc4=0, ifid_valid=0, imem_req=0.
REQ-031 Reset SHALL override redirect, stall and imem_ack; an in-flight request SHALL be abandoned and a late ack after reset ignored while IDLE.
REQ-032 The first request SHALL assert on the cycle after reset_n rises, at address RESET_PC.

Verification
REQ-033 Zero-wait memory (ack=req), no stall: ifid_ir carries IMem[0], [4], [8]... on consecutive cycles, ifid_pc4 = 4, 8, 12.
REQ-034 Stall held for 6 cycles with ack always 1: fifo_count saturates at 4, imem_req drops, and after release 4 queued words emerge in order with no loss or duplication.
REQ-035 Redirect to 32'h40 while a 3-cycle-latency request for 32'h8 is pending: the 32'h8 data is discarded (DROP), the next ifid_valid word is IMem[0x40] with ifid_pc4=32'h44.
REQ-036 Redirect and stall asserted in the same cycle with the queue holding 2 entries: next edge gives ifid_valid=0, fifo_count=0, and fetch restarts at redirect_pc.
REQ-037 Reset asserted mid-request at fpc=32'h1C, with ack arriving 1 cycle later: no push occurs, and after reset_n=1 the first imem_addr is RESET_PC.
REQ-038 redirect_pc=32'hFFFF_FFFC: fetches FFFF_FFFC then 0000_0000 (wrap), and ifid_pc4 wraps to 0 then 4.

Source files
------------

// File: rtl/ifetch_queue.sv
// Instruction fetch unit: a three-state request FSM feeding a small prefetch queue,
// with a registered IF/ID output stage that handles stall, redirect and flush.
module ifetch_queue #(
    parameter int          DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic                     clock,
    input  logic                     reset_n,
    output logic                     imem_req,
    output logic [31:0]              imem_addr,
    input  logic                     imem_ack,
    input  logic [31:0]              imem_rdata,
    input  logic                     redirect,
    input  logic [31:0]              redirect_pc,
    input  logic                     stall,
    output logic [31:0]              ifid_ir,
    output logic [31:0]              ifid_pc4,
    output logic                     ifid_valid,
    output logic [$clog2(DEPTH):0]   fifo_count
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    typedef enum logic [1:0] {ST_IDLE, ST_REQ, ST_DROP} state_t;

    state_t          state_q;
    logic [31:0]     fpc_q;
    logic [31:0]     addr_q;
    logic            req_q;
    logic [PW-1:0]   head_q;
    logic [PW-1:0]   tail_q;
    logic [CW-1:0]   count_q;
    logic [31:0]     ir_q;
    logic [31:0]     pc4_q;
    logic            valid_q;

    logic [31:0]     ir_mem  [DEPTH];
    logic [31:0]     pc4_mem [DEPTH];

    logic [31:0]     rpc_aligned;
    logic [31:0]     fpc_plus4;
    logic            pop;
    logic            push;
    logic [CW-1:0]   count_popped;
    logic [CW-1:0]   count_d;

    always_comb begin
        rpc_aligned  = redirect_pc & ~32'h3;
        fpc_plus4    = fpc_q + 32'd4;
        pop          = !redirect && !stall && (count_q != '0);
        push         = (state_q == ST_REQ) && imem_ack && !redirect;
        count_popped = count_q - {{(CW-1){1'b0}}, pop};
        count_d      = redirect ? '0 : count_popped + {{(CW-1){1'b0}}, push};
    end

    // Fetch FSM; a slot is only requested when it is guaranteed free at ack time.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
            fpc_q   <= RESET_PC;
            addr_q  <= RESET_PC & ~32'h3;
            req_q   <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (redirect) begin
                        state_q <= ST_REQ;
                        fpc_q   <= rpc_aligned;
                        addr_q  <= rpc_aligned;
                        req_q   <= 1'b1;
                    end else if (count_popped < FULL) begin
                        state_q <= ST_REQ;
                        addr_q  <= fpc_q;
                        req_q   <= 1'b1;
                    end
                end
                ST_REQ: begin
                    if (redirect) begin
                        fpc_q <= rpc_aligned;
                        if (imem_ack) begin
                            addr_q <= rpc_aligned;
                        end else begin
                            state_q <= ST_DROP;
                        end
                    end else if (imem_ack) begin
                        fpc_q <= fpc_plus4;
                        if (count_d < FULL) begin
                            addr_q <= fpc_plus4;
                        end else begin
                            state_q <= ST_IDLE;
                            req_q   <= 1'b0;
                        end
                    end
                end
                ST_DROP: begin
                    // The stale request keeps its address until the memory completes it.
                    if (imem_ack) begin
                        state_q <= ST_REQ;
                        if (redirect) begin
                            fpc_q  <= rpc_aligned;
                            addr_q <= rpc_aligned;
                        end else begin
                            addr_q <= fpc_q;
                        end
                    end else if (redirect) begin
                        fpc_q <= rpc_aligned;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                    req_q   <= 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (push && reset_n) begin
            ir_mem[tail_q]  <= imem_rdata;
            pc4_mem[tail_q] <= fpc_plus4;
        end
    end

    // Queue pointers and the IF/ID register; redirect flushes both.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            ir_q    <= '0;
            pc4_q   <= '0;
            valid_q <= 1'b0;
        end else begin
            count_q <= count_d;
            if (redirect) begin
                head_q  <= '0;
                tail_q  <= '0;
                ir_q    <= '0;
                valid_q <= 1'b0;
            end else begin
                if (pop) begin
                    head_q  <= head_q + PW'(1);
                    ir_q    <= ir_mem[head_q];
                    pc4_q   <= pc4_mem[head_q];
                    valid_q <= 1'b1;
                end else if (!stall) begin
                    ir_q    <= '0;
                    valid_q <= 1'b0;
                end
                if (push) begin
                    tail_q <= tail_q + PW'(1);
                end
            end
        end
    end

    assign imem_req   = req_q;
    assign imem_addr  = addr_q;
    assign ifid_ir    = ir_q;
    assign ifid_pc4   = pc4_q;
    assign ifid_valid = valid_q;
    assign fifo_count = count_q;

endmodule

// File: tb/tb_ifetch_queue.sv
// Bench for ifetch_queue: directed scenarios then random traffic, scored against
// a queue-based model of the expected instruction stream and fetch addresses.
module tb_ifetch_queue;
    localparam int          DEPTH    = 4;
    localparam logic [31:0] RESET_PC = 32'h0000_0000;

    logic        clock = 1'b0;
    logic        reset_n;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        stall;
    logic [31:0] ifid_ir;
    logic [31:0] ifid_pc4;
    logic        ifid_valid;
    logic [$clog2(DEPTH):0] fifo_count;

    always #5 clock = ~clock;

    ifetch_queue #(.DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
        .clock(clock), .reset_n(reset_n),
        .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_ack(imem_ack), .imem_rdata(imem_rdata),
        .redirect(redirect), .redirect_pc(redirect_pc), .stall(stall),
        .ifid_ir(ifid_ir), .ifid_pc4(ifid_pc4), .ifid_valid(ifid_valid),
        .fifo_count(fifo_count)
    );

    typedef struct packed {
        logic [31:0] ir;
        logic [31:0] pc4;
    } entry_t;

    int          checks = 0;
    int          errors = 0;
    entry_t      q[$];
    logic [31:0] exp_ir, exp_pc4, exp_fetch;
    logic        exp_valid, stale;
    int          waited, lat, lat_max;

    function automatic logic [31:0] memf(input logic [31:0] a);
        return {a[15:0], ~a[31:16]} ^ 32'h5A5A_1234;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    // One clock: drive inputs, advance the model, take the edge, compare.
    // fa=1 forces imem_ack to ack_v; otherwise the memory model acks after 'lat' waits.
    task automatic step(input logic rst_v, input logic redir_v, input logic [31:0] rpc_v,
                        input logic stall_v, input logic fa, input logic ack_v);
        logic        req_s, ack_s, push, popped;
        logic [31:0] addr_s;
        entry_t      e;
        req_s  = imem_req;
        addr_s = imem_addr;
        ack_s  = fa ? ack_v : (req_s && (waited >= lat));
        reset_n     = rst_v;
        redirect    = redir_v;
        redirect_pc = rpc_v;
        stall       = stall_v;
        imem_ack    = ack_s;
        imem_rdata  = ack_s ? memf(addr_s) : $urandom();
        push   = 1'b0;
        popped = 1'b0;
        if (!rst_v) begin
            q.delete();
            stale     = 1'b0;
            exp_fetch = RESET_PC;
            exp_ir    = '0;
            exp_pc4   = '0;
            exp_valid = 1'b0;
        end else begin
            push = ack_s && req_s && !redir_v && !stale;
            if (push) chk("fetch_addr", addr_s, exp_fetch);
            if (redir_v) stale = req_s && !ack_s;
            else if (ack_s && req_s) stale = 1'b0;
            if (redir_v) begin
                q.delete();
                exp_ir    = '0;
                exp_valid = 1'b0;
                exp_fetch = rpc_v & ~32'h3;
            end else if (!stall_v && q.size() != 0) begin
                e         = q.pop_front();
                exp_ir    = e.ir;
                exp_pc4   = e.pc4;
                exp_valid = 1'b1;
                popped    = 1'b1;
            end else if (!stall_v) begin
                exp_ir    = '0;
                exp_valid = 1'b0;
            end
            if (push) begin
                e.ir  = imem_rdata;
                e.pc4 = exp_fetch + 32'd4;
                q.push_back(e);
                exp_fetch = exp_fetch + 32'd4;
            end
        end
        @(posedge clock);
        #1;
        chk("ifid_valid", 32'(ifid_valid), 32'(exp_valid));
        chk("ifid_ir", ifid_ir, exp_ir);
        chk("ifid_pc4", ifid_pc4, exp_pc4);
        chk("fifo_count", 32'(fifo_count), 32'(q.size()));
        chk("addr_align", 32'(imem_addr[1:0]), 32'd0);
        if (!rst_v) chk("reset_req", 32'(imem_req), 32'd0);
        if (rst_v && req_s && !ack_s) begin
            chk("req_hold", 32'(imem_req), 32'd1);
            chk("addr_hold", imem_addr, addr_s);
        end
        if (popped)
            $display("pop pc4=%h ir=%h count=%0d", ifid_pc4, ifid_ir, fifo_count);
        if (!rst_v || !req_s) waited = 0;
        else if (ack_s) begin
            waited = 0;
            lat    = int'($urandom_range(lat_max, 0));
        end else waited++;
    endtask

    initial begin
        logic        found;
        logic        rr, rd, rs;
        logic [31:0] rp;
        reset_n = 1'b0; redirect = 1'b0; redirect_pc = '0; stall = 1'b0;
        imem_ack = 1'b0; imem_rdata = '0;
        exp_ir = '0; exp_pc4 = '0; exp_fetch = RESET_PC; exp_valid = 1'b0; stale = 1'b0;
        waited = 0; lat = 0; lat_max = 0;

        // Reset, first request, zero-wait streaming
        step(0, 0, 0, 0, 1, 0);
        step(0, 0, 0, 0, 1, 0);
        step(1, 0, 0, 0, 1, 0);
        chk("first_req", 32'(imem_req), 32'd1);
        chk("first_addr", imem_addr, RESET_PC);
        for (int i = 0; i < 10; i++) begin
            step(1, 0, 0, 0, 0, 0);
            if (i >= 1) begin
                chk("stream_pc4", ifid_pc4, 32'(4 * i));
                chk("stream_ir", ifid_ir, memf(32'(4 * (i - 1))));
            end
        end

        // Stall saturation and drain
        for (int i = 0; i < 6; i++) step(1, 0, 0, 1, 0, 0);
        chk("stall_count", 32'(fifo_count), 32'd4);
        chk("stall_req", 32'(imem_req), 32'd0);
        for (int i = 0; i < 8; i++) step(1, 0, 0, 0, 0, 0);

        // Redirect while a slow fetch of 0x8 is pending
        step(0, 0, 0, 0, 1, 0);
        step(1, 0, 0, 0, 1, 0);
        step(1, 0, 0, 0, 1, 1);
        step(1, 0, 0, 0, 1, 1);
        step(1, 0, 0, 0, 1, 0);
        step(1, 0, 0, 0, 1, 0);
        chk("pend_addr", imem_addr, 32'h8);
        step(1, 1, 32'h40, 0, 1, 0);
        chk("drop_req", 32'(imem_req), 32'd1);
        chk("drop_addr", imem_addr, 32'h8);
        step(1, 0, 0, 0, 1, 1);
        chk("drop_count", 32'(fifo_count), 32'd0);
        chk("restart_addr", imem_addr, 32'h40);
        found = 1'b0;
        for (int i = 0; i < 8 && !found; i++) begin
            step(1, 0, 0, 0, 0, 0);
            if (ifid_valid) begin
                found = 1'b1;
                chk("redir_pc4", ifid_pc4, 32'h44);
                chk("redir_ir", ifid_ir, memf(32'h40));
            end
        end
        if (!found) chk("redir_timeout", 32'd0, 32'd1);

        // Redirect together with stall while two entries are queued
        step(0, 0, 0, 0, 1, 0);
        step(1, 0, 0, 1, 1, 0);
        step(1, 0, 0, 1, 1, 1);
        step(1, 0, 0, 1, 1, 1);
        chk("two_queued", 32'(fifo_count), 32'd2);
        step(1, 1, 32'h100, 1, 1, 1);
        chk("rs_valid", 32'(ifid_valid), 32'd0);
        chk("rs_count", 32'(fifo_count), 32'd0);
        chk("rs_addr", imem_addr, 32'h100);
        for (int i = 0; i < 6; i++) step(1, 0, 0, 0, 0, 0);

        // Reset during a fetch of 0x1C, late ack afterwards
        step(1, 1, 32'h1C, 0, 1, imem_req);
        step(1, 0, 0, 0, 1, 0);
        chk("mid_addr", imem_addr, 32'h1C);
        step(0, 0, 0, 0, 1, 0);
        step(1, 0, 0, 0, 1, 1);
        chk("late_count", 32'(fifo_count), 32'd0);
        chk("post_rst_req", 32'(imem_req), 32'd1);
        chk("post_rst_addr", imem_addr, RESET_PC);

        // Address wrap at the top of memory
        step(1, 1, 32'hFFFF_FFFC, 0, 0, 0);
        chk("wrap_addr", imem_addr, 32'hFFFF_FFFC);
        for (int i = 0; i < 4; i++) begin
            step(1, 0, 0, 0, 0, 0);
            if (i == 1) chk("wrap_pc4_0", ifid_pc4, 32'h0);
            if (i == 2) chk("wrap_pc4_4", ifid_pc4, 32'h4);
        end

        // Random traffic
        lat_max = 3;
        for (int i = 0; i < 3000; i++) begin
            rr = ($urandom_range(99, 0) != 0);
            rd = ($urandom_range(99, 0) < 5);
            rp = ($urandom_range(3, 0) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(15, 0)))
                                              : $urandom();
            rs = ($urandom_range(99, 0) < 35);
            step(rr, rd, rp, rs, 0, 0);
        end
        lat_max = 0;
        for (int i = 0; i < 12; i++) step(1, 0, 0, 0, 0, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
